// File: rtl/fp_arb_pkg.sv
// Shared definitions for the shared-adder arbiter: format widths, field helpers, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_arb_pkg;

  localparam int FP_EXP_W  = 4;
  localparam int FP_FRAC_W = 8;
  localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] v);
    return v[FP_W-1];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[FP_W-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_FRAC_W-1:0] fp_frac(input logic [FP_W-1:0] v);
    return v[FP_FRAC_W-1:0];
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input logic s,
                                             input logic [FP_EXP_W-1:0] e,
                                             input logic [FP_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester/consumer bundle for the shared adder: two operand requests in, one result out.
// Latency: n/a (wiring only).
// Backpressure: res_ready holds the result; req is held by the requester until its gnt.
interface fp_add_arbiter_if;
  import fp_arb_pkg::*;

  logic            req0;
  logic            req1;
  logic [FP_W-1:0] op0a;
  logic [FP_W-1:0] op0b;
  logic [FP_W-1:0] op1a;
  logic [FP_W-1:0] op1b;
  logic            gnt0;
  logic            gnt1;
  logic [FP_W-1:0] res;
  logic            res_valid;
  logic            res_id;
  logic            res_ready;
  logic            busy;

  // Board-side view: requesters and result consumer.
  modport master (
    output req0, req1, op0a, op0b, op1a, op1b, res_ready,
    input  gnt0, gnt1, res, res_valid, res_id, busy
  );

  // Arbiter view.
  modport slave (
    input  req0, req1, op0a, op0b, op1a, op1b, res_ready,
    output gnt0, gnt1, res, res_valid, res_id, busy
  );

endinterface

// File: rtl/fp_adder.sv
// Combinational 13-bit float adder {sign, exp[3:0], frac[7:0]} with explicit leading one, truncating.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module fp_adder
  import fp_arb_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic                 a_big;
  logic                 sa, sb, rs;
  logic [FP_EXP_W-1:0]  ea, eb, diff, re;
  logic [FP_FRAC_W-1:0] fa, fb, fs, d, rf;
  logic [FP_FRAC_W:0]   sum9;
  logic [2:0]           lz;

  // Order operands by magnitude, align the smaller, add or subtract, then renormalise.
  always_comb begin
    a_big = {fp_exp(a), fp_frac(a)} >= {fp_exp(b), fp_frac(b)};
    sa    = a_big ? fp_sign(a) : fp_sign(b);
    sb    = a_big ? fp_sign(b) : fp_sign(a);
    ea    = a_big ? fp_exp(a)  : fp_exp(b);
    eb    = a_big ? fp_exp(b)  : fp_exp(a);
    fa    = a_big ? fp_frac(a) : fp_frac(b);
    fb    = a_big ? fp_frac(b) : fp_frac(a);
    diff  = ea - eb;
    fs    = fb >> diff;
    sum9  = '0;
    d     = '0;
    lz    = '0;
    rs    = sa;
    re    = ea;
    rf    = '0;
    if (sa == sb) begin
      sum9 = {1'b0, fa} + {1'b0, fs};
      if (sum9[FP_FRAC_W]) begin
        // Carry out: shift right one place; saturate at the top exponent.
        if (ea == '1) begin
          re = '1;
          rf = '1;
        end else begin
          re = ea + 4'd1;
          rf = sum9[FP_FRAC_W:1];
        end
      end else begin
        rf = sum9[FP_FRAC_W-1:0];
      end
    end else begin
      d = fa - fs;
      // Highest set bit wins: later (higher) iterations overwrite lz.
      for (int i = 0; i < FP_FRAC_W; i++) begin
        if (d[i]) lz = 3'(7 - i);
      end
      if (d == '0 || ea < {1'b0, lz}) begin
        // Exact cancellation or underflow flushes to +0.
        rs = 1'b0;
        re = '0;
        rf = '0;
      end else begin
        re = ea - {1'b0, lz};
        rf = d << lz;
      end
    end
    sum = fp_pack(rs, re, rf);
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter sharing one fp_adder; round-robin ties, or fixed priority to requester 0 with FP_ARB_FIXED_PRIO_EN.
// Latency: request sampled T, gnt in T+1, res_valid in T+2; minimum issue interval 3 cycles.
// Backpressure: result held in RESULT until res_ready; requests are ignored outside IDLE.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter bit INIT_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  fp_add_arbiter_if.slave   bus
);

  state_t          state;
  logic [FP_W-1:0] opa_q, opb_q, sum;
  logic [FP_W-1:0] res_q;
  logic            id_q, last;
  logic            gnt0_q, gnt1_q, res_valid_q, res_id_q, busy_q;
  logic            pick_any, pick1;

  assign pick_any = bus.req0 | bus.req1;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign pick1 = bus.req1 & ~bus.req0;
`else
  // On a tie, serve whichever requester was not served last.
  assign pick1 = bus.req1 & (~bus.req0 | ~last);
`endif

  fp_adder u_adder (
    .a   (opa_q),
    .b   (opb_q),
    .sum (sum)
  );

  // Arbitration FSM: latch winner in IDLE, capture sum in CALC, hold result in RESULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      last        <= INIT_LAST;
      opa_q       <= '0;
      opb_q       <= '0;
      id_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            opa_q  <= pick1 ? bus.op1a : bus.op0a;
            opb_q  <= pick1 ? bus.op1b : bus.op0b;
            id_q   <= pick1;
            gnt0_q <= ~pick1;
            gnt1_q <= pick1;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          res_q       <= sum;
          res_valid_q <= 1'b1;
          res_id_q    <= id_q;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          state       <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            last        <= res_id_q;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: reset, single request, tie arbitration, back-pressure, cancellation, resets mid-flight.
// Latency: checks gnt at T+1 and res_valid at T+2 against hand-computed values.
// Backpressure: holds res_ready low for five cycles and checks the result and late request stay parked.
module tb_fp_add_arbiter;

  localparam logic [12:0] ONE      = 13'h0880; // +1.0
  localparam logic [12:0] ONE5     = 13'h08C0; // +1.5
  localparam logic [12:0] TWO      = 13'h0980; // +2.0
  localparam logic [12:0] TWO5     = 13'h09A0; // +2.5
  localparam logic [12:0] NEG_ONE  = 13'h1880; // -1.0
  localparam logic [12:0] NEG_ONE5 = 13'h18C0; // -1.5
  localparam logic [12:0] HALF     = 13'h0780; // +0.5

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_add_arbiter_if bus ();

  fp_add_arbiter #(.INIT_LAST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one requester-0 transaction of ONE+ONE to completion (leaves last = 0).
  task automatic run_req0();
    bus.res_ready = 1'b1;
    bus.op0a = ONE;
    bus.op0b = ONE;
    bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b want 0", bus.gnt0); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b want 0", bus.gnt1); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.res !== 13'h0000) begin n_fail++; $display("FAIL reset_res: got %h want 0000", bus.res); end
    n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id: got %b want 0", bus.res_id); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    bus.res_ready = 1'b1;
    bus.op0a = ONE;
    bus.op0b = ONE;
    bus.req0 = 1'b1;
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt_T: got %b want 0", bus.gnt0); end
    @(negedge clk); // T+1
    n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0_T1: got %b want 1", bus.gnt0); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1_T1: got %b want 0", bus.gnt1); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T1: got %b want 1", bus.busy); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T1: got %b want 0", bus.res_valid); end
    bus.req0 = 1'b0;
    @(negedge clk); // T+2
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_T2: got %b want 1", bus.res_valid); end
    n_checks++; if (bus.res !== TWO) begin n_fail++; $display("FAIL single_res: got %h want %h", bus.res, TWO); end
    n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL single_res_id: got %b want 0", bus.res_id); end
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_T2: got %b want 0", bus.gnt0); end
    @(negedge clk); // T+3
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T3: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T3: got %b want 0", bus.busy); end
  endtask

  task automatic test_tie();
    logic exp_id;
    logic exp_g0;
    logic exp_g1;
    do_reset();
    bus.res_ready = 1'b1;
    bus.op0a = ONE;
    bus.op0b = ONE;
    bus.op1a = ONE;
    bus.op1b = ONE5;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
`ifdef FP_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = 1'(((c - 1) / 3) % 2);
`endif
      exp_g0 = ((c - 1) % 3 == 0) && !exp_id;
      exp_g1 = ((c - 1) % 3 == 0) && exp_id;
      n_checks++; if (bus.gnt0 !== exp_g0) begin n_fail++; $display("FAIL tie_gnt0 c%0d: got %b want %b", c, bus.gnt0, exp_g0); end
      n_checks++; if (bus.gnt1 !== exp_g1) begin n_fail++; $display("FAIL tie_gnt1 c%0d: got %b want %b", c, bus.gnt1, exp_g1); end
      if ((c - 1) % 3 == 1) begin
        n_checks++; if (bus.res_id !== exp_id) begin n_fail++; $display("FAIL tie_res_id c%0d: got %b want %b", c, bus.res_id, exp_id); end
        n_checks++; if (bus.res !== (exp_id ? TWO5 : TWO)) begin n_fail++; $display("FAIL tie_res c%0d: got %h want %h", c, bus.res, exp_id ? TWO5 : TWO); end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.res_ready = 1'b0;
    bus.op0a = ONE;
    bus.op0b = ONE;
    bus.op1a = ONE;
    bus.op1b = ONE5;
    bus.req0 = 1'b1;
    @(negedge clk); // c1
    n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL bp_gnt0: got %b want 1", bus.gnt0); end
    bus.req0 = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      n_checks++; if (bus.res !== TWO) begin n_fail++; $display("FAIL bp_res c%0d: got %h want %h", c, bus.res, TWO); end
      n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want 1", c, bus.res_valid); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy c%0d: got %b want 1", c, bus.busy); end
      n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_gnt1 c%0d: got %b want 0", c, bus.gnt1); end
      if (c == 3) bus.req1 = 1'b1;
      if (c == 7) bus.res_ready = 1'b1;
    end
    @(negedge clk); // c8: back in IDLE, req1 sampled at the end of this cycle
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_c8: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_gnt1_c8: got %b want 0", bus.gnt1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_c8: got %b want 0", bus.busy); end
    @(negedge clk); // c9
    n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL bp_gnt1_c9: got %b want 1", bus.gnt1); end
    bus.req1 = 1'b0;
    @(negedge clk); // c10
    n_checks++; if (bus.res !== TWO5) begin n_fail++; $display("FAIL bp_res1: got %h want %h", bus.res, TWO5); end
    n_checks++; if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL bp_res_id1: got %b want 1", bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    bus.res_ready = 1'b1;
    bus.op1a = ONE;
    bus.op1b = NEG_ONE;
    bus.req1 = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL cancel_gnt1: got %b want 1", bus.gnt1); end
    bus.req1 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.res !== 13'h0000) begin n_fail++; $display("FAIL cancel_res: got %h want 0000", bus.res); end
    n_checks++; if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL cancel_res_id: got %b want 1", bus.res_id); end
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL cancel_valid: got %b want 1", bus.res_valid); end
    @(negedge clk);
    // Unequal exponents with opposite signs: 2.0 - 1.5 = 0.5.
    bus.op0a = TWO;
    bus.op0b = NEG_ONE5;
    bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.res !== HALF) begin n_fail++; $display("FAIL sub_res: got %h want %h", bus.res, HALF); end
    n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL sub_res_id: got %b want 0", bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_calc();
    run_req0();
    bus.req0 = 1'b1;
    @(negedge clk); // T+1, CALC
    n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rcalc_gnt0_T1: got %b want 1", bus.gnt0); end
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rcalc_gnt0: got %b want 0", bus.gnt0); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rcalc_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rcalc_busy: got %b want 0", bus.busy); end
    reset = 1'b0;
    bus.op1a = ONE;
    bus.op1b = ONE5;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rcalc_tie_gnt0: got %b want 1", bus.gnt0); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL rcalc_tie_gnt1: got %b want 0", bus.gnt1); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_result();
    run_req0();
    bus.req0 = 1'b1;
    @(negedge clk); // T+1
    bus.req0 = 1'b0;
    @(negedge clk); // T+2, RESULT with res_ready high
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL rres_valid_T2: got %b want 1", bus.res_valid); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rres_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.res !== 13'h0000) begin n_fail++; $display("FAIL rres_res: got %h want 0000", bus.res); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rres_busy: got %b want 0", bus.busy); end
    reset = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rres_tie_gnt0: got %b want 1", bus.gnt0); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL rres_tie_gnt1: got %b want 0", bus.gnt1); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0a = '0;
    bus.op0b = '0;
    bus.op1a = '0;
    bus.op1b = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_cancel();
    test_reset_calc();
    test_reset_result();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Shares a single combinational `fp_adder` (13-bit format: sign, 4-bit exponent, 8-bit fraction) between two requesters. It arbitrates between requests, latches the winning operands into the adder, registers the sum, and holds it under a valid/ready handshake until the consumer takes it. It sits between the board-level operand sources (switch/button logic, test sequencers) and the shared adder, and replaces direct wiring of the adder inputs.

## Interface
Parameters:
- `INIT_LAST`, default 1: value of the last-served register after reset. 1 means requester 0 wins the first tie.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  request valid. The requester holds it, with its operands stable, until it sees its `gnt`.
- `op0a`, `op0b`, `op1a`, `op1b`  in  13  operands, packed as `{sign, exp[3:0], frac[7:0]}`
- `gnt0`, `gnt1`  out  1  one-cycle accept pulse
- `res`  out  13  registered sum, packed as `{sign, exp, frac}`
- `res_valid`  out  1  `res` and `res_id` are valid
- `res_id`  out  1  requester that owns `res`
- `res_ready`  in  1  consumer accepts `res` this cycle
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, CALC, RESULT.
- **IDLE**
  - If no request is present, stay in IDLE.
  - If exactly one request is present, select it.
  - If both are present, select the requester that is not `last`.
  - On a selection: latch the selected operand pair into `opa_q`/`opb_q`, set `id_q`, set the matching `gnt` register to 1, and go to CALC.
- **CALC**
  - `gnt` is high for this cycle only.
  - `fp_adder` computes from `opa_q`/`opb_q`.
  - At the clock edge: `res <= adder output`, `res_valid <= 1`, `res_id <= id_q`, `gnt <= 0`. Go to RESULT.
- **RESULT**
  - Hold `res`, `res_valid` and `res_id` stable.
  - When `res_ready` is 1: `res_valid <= 0`, `last <= res_id`, go to IDLE.
  - Otherwise stay in RESULT indefinitely.
- Requests are never sampled outside IDLE. A `req` still high in CALC or RESULT is ignored.
- No arithmetic is done in this block; the adder result passes through unmodified. Operand normalization (`frac[7] = 1`) is the requester's responsibility.
- **Reset** (any state, including mid-operation):
  - state = IDLE; `gnt0` = `gnt1` = 0; `res_valid` = 0; `res` = 0; `res_id` = 0; `busy` = 0; `last` = `INIT_LAST`; `opa_q` = `opb_q` = 0.
  - Any in-flight operation is dropped silently.

## Timing
- Request sampled in cycle T.
- `gnt` is high in T+1.
- `res_valid` rises in T+2.
- Earliest next acceptance is in T+3, when `res_ready` was 1 in T+2.
- Minimum issue interval is 3 cycles. Back-pressure stretches RESULT with no limit.
- The requester drops `req` no later than the cycle after `gnt`. The FSM cannot re-grant before T+3, so no double grant is possible.
- `busy` is registered: high in T+1 through the last RESULT cycle.
- `gnt0` and `gnt1` are never high together.

## Configuration
- `FP_ARB_FIXED_PRIO_EN`
  - Defined: requester 0 always wins a tie; `last` is not used in the decision.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared package `fp_arb_pkg`:
  - `FP_EXP_W` = 4, `FP_FRAC_W` = 8, `FP_W` = 13.
  - Field-extract helpers for the packed format.
  - FSM state enumeration.
- Sub-module: the existing `fp_adder` only, instantiated once. The grant logic is small and is written inline.

## Test plan
- **Single request:** `req0`=1, `op0a`=`op0b`=`{0,8,80}` → `gnt0` pulse at T+1; `res`=`{0,9,80}`, `res_id`=0, `res_valid` at T+2.
- **Tie, round-robin:** `req0`=`req1`=1 held continuously, `res_ready`=1 → grants go 0, 1, 0, 1 at 3-cycle spacing. With `FP_ARB_FIXED_PRIO_EN` defined, grants go 0, 0, 0.
- **Back-pressure:** `res_ready`=0 for 5 cycles after `res_valid` → `res` is unchanged, `busy`=1, and a `req1` arriving meanwhile gets no `gnt1` until the cycle after `res_ready`=1.
- **Cancellation:** `op1a`=`{0,8,80}`, `op1b`=`{1,8,80}` → `res`=`{0,0,00}`, `res_id`=1.
- **Reset mid-CALC:** assert `reset` in T+1 → next cycle `gnt0`=0, `res_valid`=0, `busy`=0; a following tie grants requester 0.
- **Reset in RESULT with `res_ready`=1:** `res_valid` is 0 the next cycle and `last` returns to 1.
